systolic_frame_tx: RTL and testbench
====================================

// Module: systolic_frame_tx
// PURPOSE
// - Host-side transmitter for the 4-beat nibble-serial systolic link. Takes parallel
//   16-bit column/row words plus 4-bit control words over a valid/ready handshake.
// - Serializes each set MSB-nibble-first over one 4-cycle frame onto the tile input
//   pins (ui_in[7:4]/[3:0], uio_in[3]/[2]). Sits in the test harness / FPGA driver
//   ahead of the first tile in a chain.
// PARAMETERS
// - FIFO_DEPTH  2  input word-set FIFO entries; power of 2, >=2
// - CNT_W       8  width of underrun counter (only with SYSTOLIC_TX_UNDERRUN_CNT_EN)
// PORTS
// - clk           in   1   clock; all state on posedge
// - rst_n         in   1   reset, synchronous, active-low
// - in_valid      in   1   word set offered
// - in_ready      out  1   FIFO can accept; = !full
// - in_col        in   16  column word
// - in_row        in   16  row word
// - in_col_ctrl   in   4   column ctrl bits, bit 3 sent on beat 0
// - in_row_ctrl   in   4   row ctrl bits, bit 3 sent on beat 0
// - col_nib       out  4   to tile ui_in[7:4]
// - row_nib       out  4   to tile ui_in[3:0]
// - col_ctrl      out  1   to tile uio_in[3]
// - row_ctrl      out  1   to tile uio_in[2]
// - beat          out  2   current beat 0..3, equals the tile's frame count
// - frame_start   out  1   high when beat==0
// - frame_live    out  1   current frame carries a FIFO word (0 = idle frame)
// - fifo_level    out  $clog2(FIFO_DEPTH)+1   occupied entries
// - underrun_cnt  out  CNT_W   idle frames sent while live traffic expected (macro only)
// BEHAVIOUR
// - beat: 2-bit counter, 0 in reset, +1 every cycle, wraps 3->0. Shares rst_n with the
//   tile so both counters stay in lockstep; no resync logic.
// - Frame register F = {col16,row16,cctl4,rctl4,live}; loaded only at posedge with beat==3.
//   * FIFO non-empty: F <= head, pop, live=1.
//   * FIFO empty:     F <= all zero, live=0 (idle frame).
// - Outputs combinational from F and beat (stable across the sampling posedge):
//   col_nib=F.col[15-4*beat -:4], row_nib likewise, col_ctrl=F.cctl[3-beat], row_ctrl likewise.
// - Push at posedge when in_valid&&in_ready. No bypass: a word pushed on the same edge
//   that loads F (empty FIFO) waits for the next frame.
// - Full FIFO: in_ready=0, even on a pop edge (no same-edge push-on-pop).
// - Push+pop same edge (not full): level unchanged, order preserved.
// - Latency: push on the edge ending beat 2 goes out on beats 0..3 of the next frame.
//   Worst case is FIFO_DEPTH+1 frames.
// - Reset (any cycle, incl. mid-frame): beat=0, FIFO flushed, level=0, F=0.
//   All outputs 0 except in_ready=1 and frame_start=1. First frame after reset is always idle.
// - fifo_level: 0..FIFO_DEPTH; in_ready = (fifo_level != FIFO_DEPTH).
// CONFIGURATION
// - SYSTOLIC_TX_UNDERRUN_CNT_EN defined:
//   * underrun_cnt increments, saturating at 2^CNT_W-1, on each beat==3 edge that loads
//     an idle frame while a sticky "started" flag is set.
//   * started is set by the first push after reset; flag and counter clear on reset.
// - Not defined: underrun_cnt port absent, no counter/flag logic.
// TESTING
// - Reset, no traffic 12 cycles -> all nibbles/ctrl 0, frame_live=0, beat 0,1,2,3,0...
// - Push col=16'hA5C3,row=16'h1234,cctl=4'b1010,rctl=4'b0110 on edge ending beat 2 ->
//   next frame col_nib A,5,C,3; row_nib 1,2,3,4; col_ctrl 1,0,1,0; row_ctrl 0,1,1,0.
// - Hold in_valid, FIFO_DEPTH=2 -> in_ready drops after 2 pushes, one push accepted per
//   frame thereafter, words emitted in order with no idle frames.
// - Push only on the beat==3 edge into empty FIFO -> current frame idle, word on the
//   following frame.
// - Assert rst_n=0 at beat 2 of a live frame with FIFO level 2 -> next cycle beat=0,
//   level=0, outputs 0; prior words never emitted.
// - Macro on, CNT_W=2: push 1 word, then stall 5 frames -> underrun_cnt saturates at 3;
//   reset -> 0.

Source files
------------

// File: rtl/systolic_frame_tx.sv
// rtl/systolic_frame_tx.sv - host-side 4-beat nibble-serial systolic link transmitter
//
// Accepts parallel word sets (16-bit column, 16-bit row, 4-bit column ctrl,
// 4-bit row ctrl) over a valid/ready handshake into a small FIFO, and
// serializes one set per 4-cycle frame, MSB nibble / ctrl bit 3 first, onto
// the first tile's input pins. Frames with no queued set are sent as idle
// (all-zero) frames.
//
// Optional feature macro: SYSTOLIC_TX_UNDERRUN_CNT_EN adds the CNT_W
// parameter and the underrun_cnt output.
//
// Ports:
//   clk           in   clock, all state on posedge
//   rst_n         in   synchronous active-low reset (shared with the tile)
//   in_valid      in   word set offered
//   in_ready      out  FIFO can accept (not full)
//   in_col        in   [15:0] column word
//   in_row        in   [15:0] row word
//   in_col_ctrl   in   [3:0]  column ctrl bits, bit 3 sent on beat 0
//   in_row_ctrl   in   [3:0]  row ctrl bits, bit 3 sent on beat 0
//   col_nib       out  [3:0]  to tile ui_in[7:4]
//   row_nib       out  [3:0]  to tile ui_in[3:0]
//   col_ctrl      out  to tile uio_in[3]
//   row_ctrl      out  to tile uio_in[2]
//   beat          out  [1:0]  current beat, matches the tile's frame count
//   frame_start   out  high when beat == 0
//   frame_live    out  current frame carries a queued word set
//   fifo_level    out  occupied FIFO entries, 0..FIFO_DEPTH
//   underrun_cnt  out  [CNT_W-1:0] idle frames sent after traffic began (macro only)

module systolic_frame_tx #(
  parameter int FIFO_DEPTH = 2
`ifdef SYSTOLIC_TX_UNDERRUN_CNT_EN
  ,
  parameter int CNT_W      = 8
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [15:0]                 in_col,
  input  logic [15:0]                 in_row,
  input  logic [3:0]                  in_col_ctrl,
  input  logic [3:0]                  in_row_ctrl,
  output logic [3:0]                  col_nib,
  output logic [3:0]                  row_nib,
  output logic                        col_ctrl,
  output logic                        row_ctrl,
  output logic [1:0]                  beat,
  output logic                        frame_start,
  output logic                        frame_live,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef SYSTOLIC_TX_UNDERRUN_CNT_EN
  ,
  output logic [CNT_W-1:0]            underrun_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic [3:0]  cctl;
    logic [3:0]  rctl;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [1:0]      beat_q, beat_d;
  entry_t          frame_q, frame_d;
  logic            live_q, live_d;

  entry_t          in_entry;
  logic            push;
  logic            load;
  logic            pop;

  assign in_entry = '{col: in_col, row: in_row, cctl: in_col_ctrl, rctl: in_row_ctrl};

  // No push-on-pop when full: in_ready depends only on the registered level.
  assign in_ready = (level_q != FULL_LVL);
  assign push     = in_valid && in_ready;
  // The frame register reloads on the edge that ends beat 3; a queued entry
  // is consumed there, otherwise an idle frame follows.
  assign load     = (beat_q == 2'd3);
  assign pop      = load && (level_q != '0);

  always_comb begin
    beat_d   = beat_q + 2'd1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    frame_d  = frame_q;
    live_d   = live_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // The head is read from the registered array, so a set pushed on this
    // same edge cannot bypass into the frame even when the FIFO was empty.
    if (load) begin
      if (pop) begin
        frame_d = mem_q[rd_ptr_q];
      end else begin
        frame_d = '0;
      end
      live_d = pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q   <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      frame_q  <= '0;
      live_q   <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      frame_q  <= frame_d;
      live_q   <= live_d;
    end
  end

  // Storage needs no reset: entries are only visible through level_q.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // Lane outputs come straight from the frame register and beat counter,
  // so they are stable across the tile's sampling edge.
  assign col_nib     = frame_q.col[4'd15 - {beat_q, 2'b00} -: 4];
  assign row_nib     = frame_q.row[4'd15 - {beat_q, 2'b00} -: 4];
  assign col_ctrl    = frame_q.cctl[2'd3 - beat_q];
  assign row_ctrl    = frame_q.rctl[2'd3 - beat_q];
  assign beat        = beat_q;
  assign frame_start = (beat_q == 2'd0);
  assign frame_live  = live_q;
  assign fifo_level  = level_q;

`ifdef SYSTOLIC_TX_UNDERRUN_CNT_EN
  logic             started_q, started_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    started_d = started_q;
    cnt_d     = cnt_q;
    if (push) begin
      started_d = 1'b1;
    end
    // Count idle-frame loads only once traffic has begun; saturate at all-ones.
    if (load && !pop && started_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      started_q <= started_d;
      cnt_q     <= cnt_d;
    end
  end

  assign underrun_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_systolic_frame_tx.sv
// tb/tb_systolic_frame_tx.sv - directed self-checking bench for systolic_frame_tx

module tb_systolic_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_col, in_row;
  logic [3:0]  in_col_ctrl, in_row_ctrl;
  logic [3:0]  col_nib, row_nib;
  logic        col_ctrl, row_ctrl;
  logic [1:0]  beat;
  logic        frame_start, frame_live;
  logic [1:0]  fifo_level;
`ifdef SYSTOLIC_TX_UNDERRUN_CNT_EN
  logic [1:0]  underrun_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  systolic_frame_tx #(
    .FIFO_DEPTH(2)
`ifdef SYSTOLIC_TX_UNDERRUN_CNT_EN
    ,
    .CNT_W(2)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_col(in_col),
    .in_row(in_row),
    .in_col_ctrl(in_col_ctrl),
    .in_row_ctrl(in_row_ctrl),
    .col_nib(col_nib),
    .row_nib(row_nib),
    .col_ctrl(col_ctrl),
    .row_ctrl(row_ctrl),
    .beat(beat),
    .frame_start(frame_start),
    .frame_live(frame_live),
    .fifo_level(fifo_level)
`ifdef SYSTOLIC_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  task automatic drive_idle();
    in_valid    = 1'b0;
    in_col      = 16'h0;
    in_row      = 16'h0;
    in_col_ctrl = 4'h0;
    in_row_ctrl = 4'h0;
  endtask

  task automatic drive_word(input logic [15:0] c, input logic [15:0] r,
                            input logic [3:0] cc, input logic [3:0] rc);
    in_valid    = 1'b1;
    in_col      = c;
    in_row      = r;
    in_col_ctrl = cc;
    in_row_ctrl = rc;
  endtask

  // Advance negedge by negedge until beat equals b; ok=0 if it never does.
  task automatic wait_beat(input logic [1:0] b, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 8) begin
      @(negedge clk);
      n++;
      if (beat === b) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_word(16'hFFFF, 16'hFFFF, 4'hF, 4'hF);
    repeat (2) @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    n_tests++;
    if ({beat, frame_start, in_ready, fifo_level} !== {2'd0, 1'b1, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_ctl: got beat=%0d fs=%b rdy=%b lvl=%0d want 0 1 1 0",
               beat, frame_start, in_ready, fifo_level);
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if (beat !== 2'(i % 4) || frame_start !== (i % 4 == 0) ||
          {col_nib, row_nib, col_ctrl, row_ctrl, frame_live} !== 11'h0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got beat=%0d fs=%b lanes=%h want beat=%0d lanes=0",
                 i, beat, frame_start, {col_nib, row_nib, col_ctrl, row_ctrl, frame_live}, i % 4);
      end
    end
  endtask

  task automatic test_pattern();
    bit ok;
    logic [3:0] ec [4];
    logic [3:0] er [4];
    logic       ecc [4];
    logic       erc [4];
    ec  = '{4'hA, 4'h5, 4'hC, 4'h3};
    er  = '{4'h1, 4'h2, 4'h3, 4'h4};
    ecc = '{1'b1, 1'b0, 1'b1, 1'b0};
    erc = '{1'b0, 1'b1, 1'b1, 1'b0};
    wait_beat(2'd2, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL pattern_wait: beat 2 not reached"); end
    drive_word(16'hA5C3, 16'h1234, 4'b1010, 4'b0110);
    @(negedge clk);
    drive_idle();
    n_tests++;
    if (fifo_level !== 2'd1 || frame_live !== 1'b0) begin
      n_fail++;
      $display("FAIL pattern_queued: got lvl=%0d live=%b want 1 0", fifo_level, frame_live);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      n_tests++;
      if (beat !== 2'(b) || frame_live !== 1'b1 || col_nib !== ec[b] || row_nib !== er[b] ||
          col_ctrl !== ecc[b] || row_ctrl !== erc[b]) begin
        n_fail++;
        $display("FAIL pattern_beat%0d: got beat=%0d live=%b col=%h row=%h cc=%b rc=%b want live=1 col=%h row=%h cc=%b rc=%b",
                 b, beat, frame_live, col_nib, row_nib, col_ctrl, row_ctrl, ec[b], er[b], ecc[b], erc[b]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (beat !== 2'd0 || frame_live !== 1'b0 || col_nib !== 4'h0 || fifo_level !== 2'd0) begin
      n_fail++;
      $display("FAIL pattern_after: got beat=%0d live=%b col=%h lvl=%0d want 0 0 0 0",
               beat, frame_live, col_nib, fifo_level);
    end
  endtask

  task automatic test_no_bypass();
    bit ok;
    logic [15:0] ac, ar;
    logic [3:0]  acc, arc;
    logic        live_all;
    wait_beat(2'd3, ok);
    n_tests++;
    if (!ok || fifo_level !== 2'd0) begin
      n_fail++;
      $display("FAIL nobypass_wait: got ok=%b lvl=%0d want 1 0", ok, fifo_level);
    end
    drive_word(16'h9E07, 16'h5A5A, 4'b0011, 4'b1100);
    @(negedge clk);
    drive_idle();
    n_tests++;
    if (beat !== 2'd0 || frame_live !== 1'b0 || col_nib !== 4'h0 || fifo_level !== 2'd1) begin
      n_fail++;
      $display("FAIL nobypass_idle: got beat=%0d live=%b col=%h lvl=%0d want 0 0 0 1",
               beat, frame_live, col_nib, fifo_level);
    end
    repeat (4) @(negedge clk);
    live_all = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      ac  = {ac[11:0], col_nib};
      ar  = {ar[11:0], row_nib};
      acc = {acc[2:0], col_ctrl};
      arc = {arc[2:0], row_ctrl};
      live_all = live_all & frame_live;
    end
    n_tests++;
    if ({ac, ar, acc, arc} !== {16'h9E07, 16'h5A5A, 4'b0011, 4'b1100} || live_all !== 1'b1) begin
      n_fail++;
      $display("FAIL nobypass_word: got col=%h row=%h cc=%b rc=%b live=%b want 9e07 5a5a 0011 1100 1",
               ac, ar, acc, arc, live_all);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k;
    int m;
    logic [15:0] wcol [5];
    logic [15:0] wrow [5];
    logic [3:0]  wcc  [5];
    logic [3:0]  wrc  [5];
    logic [15:0] ac, ar;
    logic [3:0]  acc, arc;
    logic        live_all;
    wcol = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hF0E1};
    wrow = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210, 16'h0F1E};
    wcc  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
    wrc  = '{4'hE, 4'hD, 4'hB, 4'h7, 4'h0};
    wait_beat(2'd0, ok);
    n_tests++;
    if (!ok || fifo_level !== 2'd0) begin
      n_fail++;
      $display("FAIL b2b_wait: got ok=%b lvl=%0d want 1 0", ok, fifo_level);
    end
    k = 0;
    live_all = 1'b1;
    for (int c = 0; c < 28; c++) begin
      if (c > 0) @(negedge clk);
      ac  = {ac[11:0], col_nib};
      ar  = {ar[11:0], row_nib};
      acc = {acc[2:0], col_ctrl};
      arc = {arc[2:0], row_ctrl};
      live_all = live_all & frame_live;
      if (c == 2) begin
        n_tests++;
        if (in_ready !== 1'b0 || fifo_level !== 2'd2) begin
          n_fail++;
          $display("FAIL b2b_full: got rdy=%b lvl=%0d want 0 2", in_ready, fifo_level);
        end
      end
      if (c == 4) begin
        n_tests++;
        if (in_ready !== 1'b1 || fifo_level !== 2'd1) begin
          n_fail++;
          $display("FAIL b2b_reopen: got rdy=%b lvl=%0d want 1 1", in_ready, fifo_level);
        end
      end
      if (c % 4 == 3) begin
        m = c / 4;
        if (m >= 1 && m <= 5) begin
          n_tests++;
          if ({ac, ar, acc, arc} !== {wcol[m-1], wrow[m-1], wcc[m-1], wrc[m-1]} || live_all !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_frame%0d: got col=%h row=%h cc=%h rc=%h live=%b want %h %h %h %h 1",
                     m, ac, ar, acc, arc, live_all, wcol[m-1], wrow[m-1], wcc[m-1], wrc[m-1]);
          end
        end else if (m == 6) begin
          n_tests++;
          if (frame_live !== 1'b0 || ac !== 16'h0) begin
            n_fail++;
            $display("FAIL b2b_tail_idle: got live=%b col=%h want 0 0", frame_live, ac);
          end
        end
        live_all = 1'b1;
      end
      if (k < 5) begin
        drive_word(wcol[k], wrow[k], wcc[k], wrc[k]);
        if (in_ready) k++;
      end else begin
        drive_idle();
      end
    end
    drive_idle();
    n_tests++;
    if (k !== 5) begin
      n_fail++;
      $display("FAIL b2b_accepted: got %0d want 5", k);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit clean;
    wait_beat(2'd2, ok);
    drive_word(16'hDEAD, 16'hBEEF, 4'hC, 4'h3);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    drive_word(16'h1357, 16'h2468, 4'h9, 4'h6);
    @(negedge clk);
    drive_word(16'hACE1, 16'hBDF2, 4'h5, 4'hA);
    @(negedge clk);
    drive_idle();
    n_tests++;
    if (!ok || beat !== 2'd2 || frame_live !== 1'b1 || fifo_level !== 2'd2) begin
      n_fail++;
      $display("FAIL midrst_setup: got ok=%b beat=%0d live=%b lvl=%0d want 1 2 1 2",
               ok, beat, frame_live, fifo_level);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({beat, fifo_level, frame_live, in_ready, frame_start} !== {2'd0, 2'd0, 1'b0, 1'b1, 1'b1} ||
        {col_nib, row_nib, col_ctrl, row_ctrl} !== 10'h0) begin
      n_fail++;
      $display("FAIL midrst_state: got beat=%0d lvl=%0d live=%b rdy=%b fs=%b lanes=%h want 0 0 0 1 1 0",
               beat, fifo_level, frame_live, in_ready, frame_start, {col_nib, row_nib, col_ctrl, row_ctrl});
    end
    rst_n = 1'b1;
    clean = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (frame_live !== 1'b0 || {col_nib, row_nib, col_ctrl, row_ctrl} !== 10'h0) clean = 1'b0;
    end
    n_tests++;
    if (clean !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_flushed: got clean=%b want 1", clean);
    end
  endtask

`ifdef SYSTOLIC_TX_UNDERRUN_CNT_EN
  task automatic test_underrun();
    bit ok;
    do_reset();
    repeat (8) @(negedge clk);
    n_tests++;
    if (underrun_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL underrun_prestart: got %0d want 0", underrun_cnt);
    end
    wait_beat(2'd2, ok);
    drive_word(16'h0F0F, 16'hF0F0, 4'h1, 4'h2);
    @(negedge clk);
    drive_idle();
    repeat (5) @(negedge clk);
    n_tests++;
    if (underrun_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL underrun_first: got %0d want 1", underrun_cnt);
    end
    repeat (15) @(negedge clk);
    n_tests++;
    if (underrun_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL underrun_sat: got %0d want 3", underrun_cnt);
    end
    do_reset();
    n_tests++;
    if (underrun_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL underrun_reset: got %0d want 0", underrun_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_pattern();
    test_no_bypass();
    test_back_to_back();
    test_reset_mid();
`ifdef SYSTOLIC_TX_UNDERRUN_CNT_EN
    test_underrun();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
